// File: rtl/wired_lsu_pipe_pkg.sv
// rtl/wired_lsu_pipe_pkg.sv - shared wired LSU request/response types, FSM states and exception codes
package wired_lsu_pipe_pkg;

  localparam int WID_W = 4;

  localparam logic [5:0] ECODE_NONE = 6'h00;
  localparam logic [5:0] ECODE_ADEM = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_BUSREQ,
    LSU_WAIT,
    LSU_RESP,
    LSU_DRAIN
  } lsu_state_e;

  typedef struct packed {
    logic [WID_W-1:0] wid;
    logic [31:0]      vaddr;
    logic [1:0]       msize;
    logic [3:0]       strb;
    logic [31:0]      wdata;
    logic             cacop;
    logic             dbar;
    logic             llsc;
  } iq_lsu_req_t;

  typedef struct packed {
    logic [WID_W-1:0] wid;
    logic [5:0]       excp;
    logic [31:0]      vaddr;
    logic             uncached;
    logic [31:0]      rdata;
  } iq_lsu_resp_t;

  function automatic logic lsu_is_uncached(input logic [31:0] vaddr, input logic [3:0] seg);
    return vaddr[31:28] == seg;
  endfunction

endpackage

// File: rtl/wired_lsu_pipe_align.sv
// rtl/wired_lsu_pipe_align.sv - misalignment check and load-data right shift
module wired_lsu_align
  import wired_lsu_pipe_pkg::*;
(
  input  logic [1:0]  msize_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] bus_rdata_i,
  output logic        misaligned_o,
  output logic [31:0] load_data_o
);

  assign misaligned_o = ((msize_i == 2'd3) && (addr_lo_i != 2'b00)) ||
                        ((msize_i == 2'd1) && addr_lo_i[0]);

  assign load_data_o = bus_rdata_i >> {addr_lo_i, 3'b000};

endmodule

// File: rtl/wired_lsu_pipe.sv
// rtl/wired_lsu_pipe.sv - blocking one-in-flight LSU pipe; define WIRED_LSU_LLSC_EN for ll/sc llbit support
module wired_lsu_pipe
  import wired_lsu_pipe_pkg::*;
#(
  parameter logic [3:0] UC_SEG      = 4'hA,
  parameter int         BUS_TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  iq_lsu_req_t  req_i,
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output iq_lsu_resp_t resp_o,
  output logic         bus_req_valid_o,
  input  logic         bus_req_ready_i,
  output logic [31:0]  bus_addr_o,
  output logic         bus_we_o,
  output logic [3:0]   bus_strb_o,
  output logic [31:0]  bus_wdata_o,
  output logic         bus_uc_o,
  input  logic         bus_resp_valid_i,
  input  logic [31:0]  bus_rdata_i,
  input  logic         bus_err_i
);

  if (BUS_TIMEOUT != 0) begin : g_bus_timeout_unsupported
    $error("wired_lsu_pipe: BUS_TIMEOUT must be 0");
  end

  lsu_state_e  state_q, state_d;
  iq_lsu_req_t req_q;
  logic [31:0] rdata_q;
  logic        err_q, mis_q;
  logic        req_ready_q, bus_valid_q, resp_valid_q;

  logic        in_idle, accept, wait_done, no_bus;
  logic        align_mis;
  logic [1:0]  align_msize, align_lo;
  logic [31:0] align_data, cap_rdata;
  logic        unused_q;

  // In IDLE the aligner checks the incoming request; afterwards it shifts bus data for the latched one.
  assign in_idle     = (state_q == LSU_IDLE);
  assign align_msize = in_idle ? req_i.msize       : req_q.msize;
  assign align_lo    = in_idle ? req_i.vaddr[1:0]  : req_q.vaddr[1:0];

  wired_lsu_align u_align (
    .msize_i      (align_msize),
    .addr_lo_i    (align_lo),
    .bus_rdata_i  (bus_rdata_i),
    .misaligned_o (align_mis),
    .load_data_o  (align_data)
  );

  assign accept    = in_idle & req_valid_i & ~flush_i;
  assign wait_done = (state_q == LSU_WAIT) & bus_resp_valid_i & ~flush_i;
  assign unused_q  = ^{req_q.cacop, req_q.dbar, req_q.llsc};

`ifdef WIRED_LSU_LLSC_EN
  logic llbit_q;
  logic in_is_sc, q_is_sc, q_is_ll;

  assign in_is_sc  = req_i.llsc & (|req_i.strb);
  assign q_is_sc   = req_q.llsc & (|req_q.strb);
  assign q_is_ll   = req_q.llsc & ~(|req_q.strb);
  assign no_bus    = align_mis | req_i.cacop | req_i.dbar | (in_is_sc & ~llbit_q);
  assign cap_rdata = (|req_q.strb) ? {31'b0, q_is_sc} : align_data;

  // Every sc clears the reservation when accepted; only a clean ll completion sets it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      llbit_q <= 1'b0;
    end else if (accept && in_is_sc) begin
      llbit_q <= 1'b0;
    end else if (wait_done && q_is_ll && !bus_err_i) begin
      llbit_q <= 1'b1;
    end
  end
`else
  assign no_bus    = align_mis | req_i.cacop | req_i.dbar;
  assign cap_rdata = (|req_q.strb) ? 32'b0 : align_data;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:   if (accept) state_d = no_bus ? LSU_RESP : LSU_BUSREQ;
      LSU_BUSREQ: begin
        if (bus_req_ready_i)  state_d = flush_i ? LSU_DRAIN : LSU_WAIT;
        else if (flush_i)     state_d = LSU_IDLE;
      end
      // A response arriving with the flush is simply dropped; nothing is left to drain.
      LSU_WAIT: begin
        if (bus_resp_valid_i) state_d = flush_i ? LSU_IDLE : LSU_RESP;
        else if (flush_i)     state_d = LSU_DRAIN;
      end
      LSU_RESP:   if (resp_ready_i || flush_i) state_d = LSU_IDLE;
      LSU_DRAIN:  if (bus_resp_valid_i) state_d = LSU_IDLE;
      default:    state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      req_q        <= '0;
      rdata_q      <= 32'b0;
      err_q        <= 1'b0;
      mis_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      bus_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= (state_d == LSU_IDLE);
      bus_valid_q  <= (state_d == LSU_BUSREQ);
      resp_valid_q <= (state_d == LSU_RESP);
      if (accept) begin
        req_q   <= req_i;
        mis_q   <= align_mis;
        err_q   <= 1'b0;
        rdata_q <= 32'b0;
      end
      if (wait_done) begin
        err_q   <= bus_err_i;
        rdata_q <= cap_rdata;
      end
    end
  end

  assign req_ready_o     = req_ready_q;
  assign bus_req_valid_o = bus_valid_q;
  assign bus_addr_o      = bus_valid_q ? {req_q.vaddr[31:2], 2'b00} : 32'b0;
  assign bus_we_o        = bus_valid_q & (|req_q.strb);
  assign bus_strb_o      = bus_valid_q ? req_q.strb : 4'b0;
  assign bus_wdata_o     = bus_valid_q ? req_q.wdata : 32'b0;
  assign bus_uc_o        = bus_valid_q & lsu_is_uncached(req_q.vaddr, UC_SEG);
  assign resp_valid_o    = resp_valid_q;

  always_comb begin
    resp_o = '0;
    if (resp_valid_q) begin
      resp_o.wid      = req_q.wid;
      resp_o.excp     = mis_q ? ECODE_ALE : (err_q ? ECODE_ADEM : ECODE_NONE);
      resp_o.vaddr    = req_q.vaddr;
      resp_o.uncached = lsu_is_uncached(req_q.vaddr, UC_SEG);
      resp_o.rdata    = rdata_q;
    end
  end

endmodule

// File: tb/tb_wired_lsu_pipe.sv
// tb/tb_wired_lsu_pipe.sv - randomized self-checking bench for wired_lsu_pipe against a transaction-level model
module tb_wired_lsu_pipe;
  import wired_lsu_pipe_pkg::*;

`ifdef WIRED_LSU_LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_i, req_valid_i, req_ready_o;
  iq_lsu_req_t  req_i;
  logic         resp_valid_o, resp_ready_i;
  iq_lsu_resp_t resp_o;
  logic         bus_req_valid_o, bus_req_ready_i;
  logic [31:0]  bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic         bus_we_o, bus_uc_o, bus_resp_valid_i, bus_err_i;
  logic [3:0]   bus_strb_o;

  always #5 clk = ~clk;

  wired_lsu_pipe #(.UC_SEG(4'hA), .BUS_TIMEOUT(0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_i            (req_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_o           (resp_o),
    .bus_req_valid_o  (bus_req_valid_o),
    .bus_req_ready_i  (bus_req_ready_i),
    .bus_addr_o       (bus_addr_o),
    .bus_we_o         (bus_we_o),
    .bus_strb_o       (bus_strb_o),
    .bus_wdata_o      (bus_wdata_o),
    .bus_uc_o         (bus_uc_o),
    .bus_resp_valid_i (bus_resp_valid_i),
    .bus_rdata_i      (bus_rdata_i),
    .bus_err_i        (bus_err_i)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic m_llbit;

  logic         exp_req_ready, exp_bus_valid, exp_resp_valid, exp_zero;
  logic [31:0]  exp_addr, exp_wdata;
  logic         exp_we, exp_uc;
  logic [3:0]   exp_strb;
  iq_lsu_resp_t exp_resp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Single compare process: every cycle, DUT outputs against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 64'(req_ready_o), 64'(exp_req_ready));
      chk("bus_req_valid", 64'(bus_req_valid_o), 64'(exp_bus_valid));
      chk("resp_valid", 64'(resp_valid_o), 64'(exp_resp_valid));
      if (exp_bus_valid) begin
        chk("bus_addr", 64'(bus_addr_o), 64'(exp_addr));
        chk("bus_we", 64'(bus_we_o), 64'(exp_we));
        chk("bus_strb", 64'(bus_strb_o), 64'(exp_strb));
        chk("bus_wdata", 64'(bus_wdata_o), 64'(exp_wdata));
        chk("bus_uc", 64'(bus_uc_o), 64'(exp_uc));
      end
      if (exp_resp_valid) begin
        chk("resp_wid", 64'(resp_o.wid), 64'(exp_resp.wid));
        chk("resp_excp", 64'(resp_o.excp), 64'(exp_resp.excp));
        chk("resp_vaddr", 64'(resp_o.vaddr), 64'(exp_resp.vaddr));
        chk("resp_uncached", 64'(resp_o.uncached), 64'(exp_resp.uncached));
        chk("resp_rdata", 64'(resp_o.rdata), 64'(exp_resp.rdata));
      end
      if (exp_zero) begin
        chk("reset_bus_payload", {bus_addr_o, bus_wdata_o}, 64'h0);
        chk("reset_bus_ctl", 64'({bus_we_o, bus_strb_o, bus_uc_o}), 64'h0);
        chk("reset_resp_payload", 64'(resp_o), 64'h0);
      end
    end
  end

  function automatic logic m_misaligned(input iq_lsu_req_t r);
    case (r.msize)
      2'd1:    return r.vaddr[0];
      2'd3:    return r.vaddr[1:0] != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_is_sc(input iq_lsu_req_t r);
    return LLSC && r.llsc && (r.strb != 4'b0);
  endfunction

  function automatic logic m_is_ll(input iq_lsu_req_t r);
    return LLSC && r.llsc && (r.strb == 4'b0);
  endfunction

  function automatic logic m_uses_bus(input iq_lsu_req_t r, input logic llbit);
    return !(m_misaligned(r) || r.cacop || r.dbar || (m_is_sc(r) && !llbit));
  endfunction

  function automatic iq_lsu_resp_t m_resp(input iq_lsu_req_t r, input logic [31:0] bdata,
                                          input logic berr, input logic went_bus);
    iq_lsu_resp_t p;
    int sh;
    p.wid      = r.wid;
    p.vaddr    = r.vaddr;
    p.uncached = (r.vaddr[31:28] == 4'hA);
    p.excp     = m_misaligned(r) ? ECODE_ALE : ((went_bus && berr) ? ECODE_ADEM : ECODE_NONE);
    sh = 8 * int'(r.vaddr[1:0]);
    if (m_misaligned(r) || r.cacop || r.dbar) p.rdata = 32'h0;
    else if (m_is_sc(r))                      p.rdata = {31'b0, went_bus};
    else if (r.strb != 4'b0)                  p.rdata = 32'h0;
    else                                      p.rdata = bdata >> sh;
    return p;
  endfunction

  function automatic iq_lsu_req_t mk_req(input logic [31:0] va, input logic [1:0] ms,
                                         input logic [3:0] st, input logic ll);
    iq_lsu_req_t r;
    r = '0;
    r.wid   = 4'($urandom);
    r.vaddr = va;
    r.msize = ms;
    r.strb  = st;
    r.wdata = $urandom;
    r.llsc  = ll;
    return r;
  endfunction

  function automatic iq_lsu_req_t rand_req();
    iq_lsu_req_t r;
    int kind;
    kind = $urandom_range(0, 11);
    r = mk_req($urandom, 2'($urandom_range(0, 3)),
               (kind < 5) ? 4'b0 : 4'($urandom_range(1, 15)), (kind == 2 || kind == 3 || kind == 7));
    if ($urandom_range(0, 1) == 1) r.vaddr[31:28] = 4'hA;
    if ($urandom_range(0, 1) == 1) r.vaddr[1:0] = 2'b00;
    r.cacop = (kind == 10);
    r.dbar  = (kind == 11);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_valid_i      = 1'b0;
    req_i            = '0;
    flush_i          = 1'b0;
    resp_ready_i     = 1'b0;
    bus_req_ready_i  = 1'b0;
    bus_resp_valid_i = 1'b0;
    bus_rdata_i      = $urandom;
    bus_err_i        = 1'b0;
  endtask

  task automatic set_exp_idle(input logic rdy);
    exp_req_ready  = rdy;
    exp_bus_valid  = 1'b0;
    exp_resp_valid = 1'b0;
    exp_zero       = 1'b0;
  endtask

  task automatic set_exp_bus(input iq_lsu_req_t r);
    exp_bus_valid = 1'b1;
    exp_addr      = {r.vaddr[31:2], 2'b00};
    exp_we        = (r.strb != 4'b0);
    exp_strb      = r.strb;
    exp_wdata     = r.wdata;
    exp_uc        = (r.vaddr[31:28] == 4'hA);
  endtask

  // fl: 0 none, 1 flush in first BUSREQ cycle, 2 flush in first WAIT cycle, 3 flush in first RESP cycle.
  task automatic run_txn(input iq_lsu_req_t r, input int rdy_wait, input int rsp_wait, input int ack_wait,
                         input int fl, input logic [31:0] bdata, input logic berr);
    logic bus, dropped;
    iq_lsu_resp_t er;
    cyc(); idle_in(); set_exp_idle(1'b1);
    req_valid_i = 1'b1;
    req_i       = r;
    bus     = m_uses_bus(r, m_llbit);
    er      = m_resp(r, bdata, berr, bus);
    dropped = 1'b0;
    if (m_is_sc(r)) m_llbit = 1'b0;
    if (bus) begin
      for (int i = 0; i <= rdy_wait; i++) begin
        cyc(); idle_in(); set_exp_idle(1'b0); set_exp_bus(r);
        bus_req_ready_i  = (i == rdy_wait);
        bus_resp_valid_i = ($urandom_range(0, 3) == 0);
        bus_err_i        = 1'($urandom);
        if (fl == 1 && i == 0) begin
          flush_i = 1'b1;
          if (rdy_wait > 0) begin
            dropped = 1'b1;
            break;
          end
        end
      end
      if (!dropped) begin
        for (int j = 0; j <= rsp_wait; j++) begin
          cyc(); idle_in(); set_exp_idle(1'b0);
          if (fl == 1 || (fl == 2 && j > 0)) flush_i = 1'($urandom);
          if (fl == 2 && j == 0) flush_i = 1'b1;
          if (j == rsp_wait) begin
            bus_resp_valid_i = 1'b1;
            bus_rdata_i      = bdata;
            bus_err_i        = berr;
          end
        end
        if (fl == 1 || fl == 2) dropped = 1'b1;
        else if (m_is_ll(r) && !berr) m_llbit = 1'b1;
      end
    end
    if (!dropped) begin
      for (int k = 0; k <= ack_wait; k++) begin
        cyc(); idle_in(); set_exp_idle(1'b0);
        exp_resp_valid   = 1'b1;
        exp_resp         = er;
        resp_ready_i     = (k == ack_wait);
        bus_resp_valid_i = ($urandom_range(0, 3) == 0);
        if (fl == 3 && k == 0) begin
          flush_i = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    for (int g = 0; g < n; g++) begin
      cyc(); idle_in(); set_exp_idle(1'b1);
      bus_resp_valid_i = ($urandom_range(0, 2) == 0);
      resp_ready_i     = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        req_valid_i = 1'b1;
        req_i       = rand_req();
        flush_i     = 1'b1;
      end
    end
  endtask

  initial begin
    iq_lsu_req_t  r35, r36, r37, rll, rsc, rw;
    iq_lsu_resp_t p;
    int fl;

    idle_in();
    rst_n   = 1'b0;
    m_llbit = 1'b0;
    set_exp_idle(1'b0);
    cyc();
    cyc(); set_exp_idle(1'b0); exp_zero = 1'b1; chk_en = 1'b1;
    cyc(); set_exp_idle(1'b0); exp_zero = 1'b1; rst_n = 1'b1;

    // Hand-computed expectations that pin the model.
    r35 = mk_req(32'h1000_0004, 2'd3, 4'b0000, 1'b0);
    p = m_resp(r35, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("pin_word_load_rdata", 64'(p.rdata), 64'hDEADBEEF);
    chk("pin_word_load_excp", 64'(p.excp), 64'h0);
    chk("pin_word_load_uc", 64'(p.uncached), 64'h0);
    r36 = mk_req(32'hA000_0003, 2'd1, 4'b1100, 1'b0);
    p = m_resp(r36, 32'h0, 1'b0, 1'b0);
    chk("pin_half_store_nobus", 64'(m_uses_bus(r36, 1'b0)), 64'h0);
    chk("pin_half_store_excp", 64'(p.excp), 64'h09);
    chk("pin_half_store_uc", 64'(p.uncached), 64'h1);
    r37 = mk_req(32'h0000_0102, 2'd0, 4'b0000, 1'b0);
    p = m_resp(r37, 32'h11223344, 1'b0, 1'b1);
    chk("pin_byte_load_rdata", 64'(p.rdata), 64'h00001122);
    p = m_resp(r37, 32'h11223344, 1'b1, 1'b1);
    chk("pin_byte_load_adem", 64'(p.excp), 64'h08);

    run_txn(r35, 0, 0, 0, 0, 32'hDEADBEEF, 1'b0);
    run_txn(r36, 0, 0, 0, 0, 32'h0, 1'b0);
    run_txn(r37, 3, 1, 0, 0, 32'h11223344, 1'b0);
    run_txn(mk_req(32'h2000_0010, 2'd3, 4'b0000, 1'b0), 0, 2, 0, 2, 32'h55AA55AA, 1'b0);
    cyc(); idle_in(); set_exp_idle(1'b1);
    run_txn(mk_req(32'hA000_0020, 2'd3, 4'b1111, 1'b0), 1, 0, 5, 0, 32'h0, 1'b0);
    run_txn(mk_req(32'h3000_0008, 2'd3, 4'b0000, 1'b0), 0, 1, 0, 0, 32'h01234567, 1'b1);

    rll = mk_req(32'h0000_0040, 2'd3, 4'b0000, 1'b1);
    rsc = mk_req(32'h0000_0040, 2'd3, 4'b1111, 1'b1);
    run_txn(rll, 0, 0, 0, 0, 32'hCAFEF00D, 1'b0);
`ifdef WIRED_LSU_LLSC_EN
    chk("pin_ll_sets_llbit", 64'(m_llbit), 64'h1);
    chk("pin_sc_uses_bus", 64'(m_uses_bus(rsc, m_llbit)), 64'h1);
    p = m_resp(rsc, 32'h0, 1'b0, 1'b1);
    chk("pin_sc_ok_rdata", 64'(p.rdata), 64'h1);
`endif
    run_txn(rsc, 0, 0, 0, 0, 32'h0, 1'b0);
`ifdef WIRED_LSU_LLSC_EN
    chk("pin_second_sc_nobus", 64'(m_uses_bus(rsc, m_llbit)), 64'h0);
`endif
    run_txn(rsc, 0, 0, 0, 0, 32'h0, 1'b0);

    // Reset while waiting for the bus abandons the access.
    rw = mk_req(32'h0000_0200, 2'd3, 4'b0000, 1'b0);
    cyc(); idle_in(); set_exp_idle(1'b1); req_valid_i = 1'b1; req_i = rw;
    cyc(); idle_in(); set_exp_idle(1'b0); set_exp_bus(rw); bus_req_ready_i = 1'b1;
    cyc(); idle_in(); set_exp_idle(1'b0); rst_n = 1'b0;
    cyc(); idle_in(); set_exp_idle(1'b0); exp_zero = 1'b1; bus_resp_valid_i = 1'b1;
    cyc(); idle_in(); set_exp_idle(1'b0); exp_zero = 1'b1; rst_n = 1'b1;
    m_llbit = 1'b0;

    for (int t = 0; t < 300; t++) begin
      fl = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
      run_txn(rand_req(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              fl, $urandom, ($urandom_range(0, 4) == 0));
      gap();
    end

    cyc(); idle_in(); set_exp_idle(1'b1);
    cyc();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
